// File: rtl/bist_resp_checker_pkg.sv
// Shared types for the BIST response checker: controller state encoding and
// the smallest read latency the expectation pipe supports.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    localparam int unsigned MIN_READ_LATENCY = 1;

endpackage

// File: rtl/bist_resp_checker_rd_pipe.sv
// Fixed-depth delay line carrying read expectations until the SRAM data returns.
// The clear input is synchronous and active-low; it empties every stage.
module bist_rd_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // shift one entry per cycle, or empty every stage on clear
    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/bist_resp_checker.sv
// BIST response checker: forwards patgen ops to the SRAM port, delays each read's
// expected word by the SRAM latency and records pass/fail plus first-failure details.
module bist_resp_checker
    import bist_pkg::*;
#(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 8,
    parameter int MASK_WIDTH   = 2,
    parameter int READ_LATENCY = 1,
    parameter int ERR_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  start,
    output logic                  pg_en,
    output logic                  pg_rst,
    input  logic [ADDR_WIDTH-1:0] pg_addr,
    input  logic                  pg_we,
    input  logic                  pg_re,
    input  logic [DATA_WIDTH-1:0] pg_data,
    input  logic [DATA_WIDTH-1:0] pg_check,
    input  logic [MASK_WIDTH-1:0] pg_wmask,
    input  logic                  pg_done,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic [MASK_WIDTH-1:0] sram_wmask,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [DATA_WIDTH-1:0] fail_expected
);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] check;
    } exp_entry_t;

    localparam int ENTRY_W = $bits(exp_entry_t);
    localparam int CNT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int PIPE_D  = (READ_LATENCY >= MIN_READ_LATENCY) ? READ_LATENCY : MIN_READ_LATENCY;

    bist_state_e           r_state;
    bist_state_e           w_state_nxt;
    logic [CNT_W-1:0]      r_drain_cnt;
    logic [CNT_W-1:0]      w_drain_cnt_nxt;
    logic                  w_clear;
    logic                  w_run;
    logic                  w_issue;
    logic                  w_mismatch;
    exp_entry_t            w_push;
    exp_entry_t            w_pop;
    logic [ENTRY_W-1:0]    w_pop_bits;

    logic                  r_fail;
    logic [ERR_WIDTH-1:0]  r_err_count;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [DATA_WIDTH-1:0] r_fail_data;
    logic [DATA_WIDTH-1:0] r_fail_expected;

    // the pg_done cycle carries no op; reset also blocks the port at once
    assign w_run   = (r_state == RUN);
    assign w_issue = w_run && !pg_done && rstb;

    // next-state and drain counter; start is only honoured once the pipe is empty
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_clear         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_clear     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (pg_done) begin
                    w_state_nxt     = DRAIN;
                    w_drain_cnt_nxt = '0;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == CNT_W'(READ_LATENCY - 1)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_clear     = 1'b1;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_drain_cnt_nxt = '0;
            end
        endcase
    end

    // controller state register
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    // an op with both enables set is executed as a write and never checked
    assign sram_ce    = w_issue && (pg_we || pg_re);
    assign sram_we    = w_issue && pg_we;
    assign sram_addr  = w_run ? pg_addr  : '0;
    assign sram_din   = w_run ? pg_data  : '0;
    assign sram_wmask = w_run ? pg_wmask : '0;

    assign w_push.valid = w_issue && pg_re && !pg_we;
    assign w_push.addr  = pg_addr;
    assign w_push.check = pg_check;

    bist_rd_pipe #(
        .DEPTH (PIPE_D),
        .WIDTH (ENTRY_W)
    ) u_rd_pipe (
        .clk     (clk),
        .i_clr_n (rstb),
        .i_d     (w_push),
        .o_q     (w_pop_bits)
    );

    assign w_pop      = w_pop_bits;
    assign w_mismatch = w_pop.valid && (sram_dout != w_pop.check);

    // result registers; details are captured only for the first mismatch after a clear
    always_ff @(posedge clk) begin
        if (!rstb || w_clear) begin
            r_fail          <= 1'b0;
            r_err_count     <= '0;
            r_fail_addr     <= '0;
            r_fail_data     <= '0;
            r_fail_expected <= '0;
        end else if (w_mismatch) begin
            r_fail <= 1'b1;
            if (r_err_count != {ERR_WIDTH{1'b1}}) begin
                r_err_count <= r_err_count + ERR_WIDTH'(1);
            end
            if (!r_fail) begin
                r_fail_addr     <= w_pop.addr;
                r_fail_data     <= sram_dout;
                r_fail_expected <= w_pop.check;
            end
        end
    end

    assign pg_en         = w_run;
    assign pg_rst        = !rstb || (r_state == IDLE) || (r_state == DONE);
    assign busy          = w_run || (r_state == DRAIN);
    assign done          = (r_state == DONE);
    assign fail          = r_fail;
    assign err_count     = r_err_count;
    assign fail_addr     = r_fail_addr;
    assign fail_data     = r_fail_data;
    assign fail_expected = r_fail_expected;

endmodule
